// File: rtl/mem_arbiter_if.sv
// Bundle between the arbiter, its two requesters (fetch, load/store) and the memory bus.
// master = arbiter side; slave = requesters plus memory (the environment).
interface mem_arbiter_if;
    logic        f_valid;
    logic [31:0] f_addr;
    logic        f_ready;
    logic [31:0] f_rdata;

    logic        d_valid;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready;
    logic [31:0] d_rdata;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        busy;
    logic        owner;
    logic        err;

    modport master (
        input  f_valid, f_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
        output f_ready, f_rdata, d_ready, d_rdata,
        output mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, owner, err
    );

    modport slave (
        output f_valid, f_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
        input  f_ready, f_rdata, d_ready, d_rdata,
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, owner, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory bus between fetch and load/store, with a per-transaction watchdog; MEM_ARB_ROUND_ROBIN_EN selects round-robin ties.
// Latency: request in IDLE at edge N -> mem_valid from N+1; ready is combinational with mem_ready (or watchdog abort).
// Backpressure: one transaction in flight; requesters hold valid until their ready pulse, extra requests wait in IDLE.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_F = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        owner_q, owner_d;
    logic        busy_q;
    logic [7:0]  wait_q, wait_d;

    logic        tie_to_d;
    logic        gnt_f, gnt_d;
    logic        abort;
    logic        f_ready_c, d_ready_c, err_c;
    logic [31:0] rdata_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Resets to "data" so the very first tie is handed to fetch.
    logic last_gnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else if (state_q == IDLE && (gnt_f || gnt_d)) begin
            last_gnt_q <= gnt_d;
        end
    end

    assign tie_to_d = ~last_gnt_q;
`else
    assign tie_to_d = 1'b1;
`endif

    assign gnt_d = bus.d_valid & (~bus.f_valid | tie_to_d);
    assign gnt_f = bus.f_valid & ~gnt_d;
    assign abort = ~bus.mem_ready & (wait_q == WAIT_LAST);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        owner_d   = owner_q;
        wait_d    = wait_q;
        f_ready_c = 1'b0;
        d_ready_c = 1'b0;
        err_c     = 1'b0;
        rdata_c   = '0;

        case (state_q)
            IDLE: begin
                if (gnt_d) begin
                    state_d = GNT_D;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    wstrb_d = bus.d_wstrb;
                    owner_d = 1'b1;
                    wait_d  = '0;
                end else if (gnt_f) begin
                    state_d = GNT_F;
                    addr_d  = bus.f_addr;
                    wdata_d = '0;
                    wstrb_d = '0;
                    owner_d = 1'b0;
                    wait_d  = '0;
                end
            end

            GNT_F, GNT_D: begin
                // An acknowledge on the abort cycle still counts as a normal completion.
                if (bus.mem_ready) begin
                    rdata_c   = bus.mem_rdata;
                    f_ready_c = (state_q == GNT_F);
                    d_ready_c = (state_q == GNT_D);
                    state_d   = IDLE;
                end else if (abort) begin
                    f_ready_c = (state_q == GNT_F);
                    d_ready_c = (state_q == GNT_D);
                    err_c     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            owner_q <= 1'b0;
            wait_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            owner_q <= owner_d;
            wait_q  <= wait_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.mem_valid = busy_q;
    assign bus.busy      = busy_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.owner     = owner_q;
    assign bus.err       = err_c;
    assign bus.f_ready   = f_ready_c;
    assign bus.d_ready   = d_ready_c;
    assign bus.f_rdata   = f_ready_c ? rdata_c : '0;
    assign bus.d_rdata   = d_ready_c ? rdata_c : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the core's single memory bus between the instruction fetch port and the load/store (data) port. It latches one request at a time, drives it onto the memory interface, and returns `mem_ready`/`mem_rdata` to the owning requester. A per-transaction watchdog aborts requests that memory never acknowledges. The block sits between the fetch/load-store stages and the memory or bus wrapper.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles a granted transaction may wait for `mem_ready` before abort; legal range 1..255.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `f_valid` in 1: fetch request, read-only.
- `f_addr` in 32: fetch address.
- `f_ready` out 1: fetch completion pulse.
- `f_rdata` out 32: fetch read data, valid when `f_ready`.
- `d_valid` in 1: data request.
- `d_addr` in 32: data address.
- `d_wdata` in 32: write data.
- `d_wstrb` in 4: byte write strobes; 0 means read.
- `d_ready` out 1: data completion pulse.
- `d_rdata` out 32: data read data, valid when `d_ready`.
- `mem_valid` out 1: request to memory.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_wstrb` out 4: memory write strobes. Forced to 0 for fetch.
- `mem_ready` in 1: memory acknowledge, one cycle.
- `mem_rdata` in 32: memory read data.
- `busy` out 1: a transaction is in flight.
- `owner` out 1: current or last grant. 0 means fetch, 1 means data.
- `err` out 1: one-cycle pulse on timeout abort.

## Operation
- States are IDLE, GNT_F and GNT_D.
- **IDLE**
  - If no requester is valid, stay in IDLE.
  - If exactly one requester is valid, grant it.
  - If both are valid, apply the priority rule (see Configuration).
  - On grant: register `mem_addr`, `mem_wdata` and `mem_wstrb` from the winner (fetch: `mem_wdata` = 0, `mem_wstrb` = 0). Set `owner`, clear the wait counter, and move to GNT_F or GNT_D.
- **GNT_x**
  - `mem_valid` = 1 and all `mem_*` outputs are held stable.
  - Requester inputs are ignored; the request is already latched. A requester dropping `valid` early is illegal and is not detected.
- **Completion**
  - On `mem_ready` in GNT_x, `x_ready` = 1 combinationally in the same cycle and `x_rdata` = `mem_rdata`. The next state is IDLE.
  - The non-owner's `ready` is always 0.
  - `mem_ready` seen while in IDLE is ignored.
- **Watchdog**
  - The 8-bit wait counter increments each GNT_x cycle in which `mem_ready` = 0.
  - When the counter equals `TIMEOUT_CYCLES - 1` and `mem_ready` = 0, the arbiter aborts: `x_ready` = 1, `x_rdata` = 0 and `err` = 1 for that cycle, and the next state is IDLE.
  - If `mem_ready` arrives on the abort cycle, it wins: normal completion, `err` = 0.
- **Requester protocol:** hold `valid` and payload stable until `ready`; deassert `valid` the cycle after `ready` unless issuing a new request.
- **Reset**
  - `mem_valid`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `busy`, `owner` and `err` = 0; the state is IDLE.
  - Reset in mid-transaction abandons the request with no `ready` pulse. Memory must tolerate `mem_valid` dropping without an acknowledge.

## Timing
- A request sampled in IDLE at edge N gives `mem_valid` = 1 from cycle N+1.
- Earliest `x_ready` is cycle N+1, when memory acknowledges in the same cycle.
- Cycle after `ready`: IDLE, `mem_valid` = 0. A request present then is granted at the following edge, so the throughput bound is 1 transaction per 2 cycles plus memory latency.
- `busy` = `mem_valid` = (state != IDLE), registered.
- `f_ready`, `d_ready`, `err` and `rdata` are combinational from `mem_ready`/`mem_rdata` and state. All other outputs are registered.

## Configuration
- Macro: `MEM_ARB_ROUND_ROBIN_EN`.
- **Defined:** a 1-bit last-grant register, reset to 1 (data), so the first tie goes to fetch.
  - On a tie, grant the port not granted last.
  - The register updates on every grant.
- **Undefined:** fixed priority. On a tie, data always wins. There is no last-grant register, and fetch can starve under continuous data traffic.

## Test plan
- **Single fetch.** `f_valid`, `f_addr` = 0x100; memory acks 2 cycles after `mem_valid` with 0xDEADBEEF.
  - Response: `mem_addr` = 0x100, `mem_wstrb` = 0.
  - Response: `f_ready` pulses once with `f_rdata` = 0xDEADBEEF.
  - Response: `d_ready` stays 0 and `mem_valid` drops on the next cycle.
- **Data write.** `d_addr` = 0x2000, `d_wdata` = 0x12345678, `d_wstrb` = 0xF; zero-wait ack.
  - Response: memory sees those exact values for 1 cycle.
  - Response: `d_ready` in the same cycle as `mem_ready`.
- **Tie, round-robin.** Both valid continuously, 3 transactions each.
  - Round-robin build: grants alternate F, D, F, D, F, D.
  - Fixed-priority build: D, D, D, then F.
- **Timeout.** `TIMEOUT_CYCLES` = 4; memory never acks.
  - Response: `d_ready` = 1, `d_rdata` = 0 and `err` = 1 exactly 4 cycles after `mem_valid` rises.
  - Response: the state returns to IDLE.
- **Ack on the abort cycle.** `mem_ready` on that same cycle gives normal data and `err` = 0.
- **Reset mid-transaction.** `rst` 1 cycle while in GNT_F.
  - Response: `mem_valid` = 0, `busy` = 0 and `owner` = 0 next cycle.
  - Response: no `f_ready` pulse.
  - Response: a new `d_valid` afterwards is granted normally.
